// File: rtl/ff_bank_if.sv
// Handshake bundle for ff_bank: control/data inputs driven by the master,
// flip-flop state and SR-violation status returned by the slave (the bank).
interface ff_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] sr_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qn, sr_err, err_cnt
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qn, sr_err, err_cnt
    );
endinterface

// File: rtl/ff_bank.sv
// Bank of WIDTH multi-mode (D/T/SR/JK) flip-flops with sticky SR-violation flags.
// Define FF_BANK_SR_CNT_EN to build the saturating violation-cycle counter on err_cnt.
module ff_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 8
) (
    input  logic     clk,
    input  logic     rst,
    ff_bank_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_SR = 2'b10,
        MODE_JK = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] viol;

    assign mode = mode_e'(bus.mode);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_d  = q_q;
        viol = '0;
        if (bus.en) begin
            unique case (mode)
                MODE_D:  q_d = bus.a;
                MODE_T:  q_d = q_q ^ bus.a;
                MODE_SR: begin
                    // S=R=1 falls through both terms and holds.
                    q_d  = (q_q | (bus.a & ~bus.b)) & ~(bus.b & ~bus.a);
                    viol = bus.a & bus.b;
                end
                MODE_JK: q_d = (bus.a & ~q_q) | (~bus.b & q_q);
                default: q_d = q_q;
            endcase
        end
        // A violation in the clearing cycle still sets its flag.
        err_d = (bus.clr_err ? '0 : err_q) | viol;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RESET_VAL;
            err_q <= '0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.qn     = ~q_q;
    assign bus.sr_err = err_q;

`ifdef FF_BANK_SR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles, not bits; clear-then-increment gives 1 on a clr_err+violation cycle.
    always_comb begin
        cnt_d = bus.clr_err ? '0 : cnt_q;
        if ((|viol) && !(&cnt_d)) begin
            cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.err_cnt = cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Randomised self-checking bench for ff_bank against a per-bit behavioural model;
// a second instance with CNT_W=2 exercises counter saturation.
module tb_ff_bank;

    localparam logic [7:0] RV = 8'hA5;
`ifdef FF_BANK_SR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en, clr;
    logic [1:0] mode;
    logic [7:0] a, b;

    ff_bank_if #(.WIDTH(8), .CNT_W(8)) bus_m ();
    ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus_s ();

    assign bus_m.en = en;  assign bus_m.mode = mode;  assign bus_m.a = a;
    assign bus_m.b = b;    assign bus_m.clr_err = clr;
    assign bus_s.en = en;  assign bus_s.mode = mode;  assign bus_s.a = a;
    assign bus_s.b = b;    assign bus_s.clr_err = clr;

    ff_bank #(.WIDTH(8), .RESET_VAL(RV), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus_m)
    );
    ff_bank #(.WIDTH(8), .RESET_VAL(RV), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state.
    logic [7:0] exp_q   = RV;
    logic [7:0] exp_err = '0;
    int         exp_cnt8 = 0;
    int         exp_cnt2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q    = RV;
        exp_err  = '0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
    endtask

    // Applies the flip-flop rules bit by bit for one enabled/disabled edge.
    task automatic model_edge();
        logic [7:0] nq   = exp_q;
        logic [7:0] vbit = '0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    2'd0: nq[i] = a[i];
                    2'd1: nq[i] = exp_q[i] ^ a[i];
                    2'd2: begin
                        if (a[i] && b[i]) vbit[i] = 1'b1;
                        else if (a[i])    nq[i] = 1'b1;
                        else if (b[i])    nq[i] = 1'b0;
                    end
                    default: begin
                        if (a[i] && b[i]) nq[i] = ~exp_q[i];
                        else if (a[i])    nq[i] = 1'b1;
                        else if (b[i])    nq[i] = 1'b0;
                    end
                endcase
            end
        end
        exp_q   = nq;
        exp_err = (clr ? 8'h00 : exp_err) | vbit;
        if (CNT_ON) begin
            if (clr) begin
                exp_cnt8 = 0;
                exp_cnt2 = 0;
            end
            if (vbit != 0) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3)   exp_cnt2++;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] av,
                        input logic [7:0] bv, input logic c);
        en = e; mode = m; a = av; b = bv; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Asserts rst mid-cycle, holds it across a rising edge, releases on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_q_now", {24'h0, bus_m.q}, 32'h0000_00A5);
        check("rst_qn_now", {24'h0, bus_m.qn}, 32'h0000_005A);
        check("rst_err_now", {24'h0, bus_m.sr_err}, 32'h0);
        check("rst_cnt_now", {24'h0, bus_m.err_cnt}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("q", {24'h0, bus_m.q}, {24'h0, exp_q});
            check("qn", {24'h0, bus_m.qn}, {24'h0, ~exp_q});
            check("sr_err", {24'h0, bus_m.sr_err}, {24'h0, exp_err});
            check("err_cnt", {24'h0, bus_m.err_cnt}, exp_cnt8);
            check("sat_q", {24'h0, bus_s.q}, {24'h0, exp_q});
            check("sat_sr_err", {24'h0, bus_s.sr_err}, {24'h0, exp_err});
            check("sat_err_cnt", {30'h0, bus_s.err_cnt}, exp_cnt2);
        end
    end

    initial begin
        en = 1'b0; mode = 2'd0; a = '0; b = '0; clr = 1'b0;

        // Power-up reset, asserted between edges.
        #1 rst = 1'b1;
        #1;
        check("init_q", {24'h0, bus_m.q}, 32'h0000_00A5);
        check("init_qn", {24'h0, bus_m.qn}, 32'h0000_005A);
        check("init_sr_err", {24'h0, bus_m.sr_err}, 32'h0);
        check("init_err_cnt", {24'h0, bus_m.err_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Directed sequence; literals pin both DUT and model.
        step(1'b1, 2'd0, 8'h3C, 8'h00, 1'b0);
        check("d_q", {24'h0, bus_m.q}, 32'h3C);
        check("model_d_q", {24'h0, exp_q}, 32'h3C);
        step(1'b0, 2'd0, 8'hFF, 8'h00, 1'b0);
        check("hold_q", {24'h0, bus_m.q}, 32'h3C);
        step(1'b1, 2'd1, 8'h0F, 8'h00, 1'b0);
        check("t_q", {24'h0, bus_m.q}, 32'h33);
        step(1'b1, 2'd3, 8'hF0, 8'hF0, 1'b0);
        check("jk_toggle_q", {24'h0, bus_m.q}, 32'hC3);
        step(1'b1, 2'd3, 8'h01, 8'h02, 1'b0);
        check("jk_setclr_q", {24'h0, bus_m.q}, 32'hC1);
        check("model_jk_q", {24'h0, exp_q}, 32'hC1);

        do_reset();
        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 8'h81, 8'h01, 1'b0);
        check("sr_q", {24'h0, bus_m.q}, 32'h80);
        check("sr_err_lit", {24'h0, bus_m.sr_err}, 32'h01);
        check("sr_cnt3", {24'h0, bus_m.err_cnt}, CNT_ON ? 32'd3 : 32'd0);
        check("model_sr_err", {24'h0, exp_err}, 32'h01);

        step(1'b1, 2'd2, 8'h10, 8'h10, 1'b1);
        check("race_sr_err", {24'h0, bus_m.sr_err}, 32'h10);
        check("race_cnt", {24'h0, bus_m.err_cnt}, CNT_ON ? 32'd1 : 32'd0);
        step(1'b0, 2'd2, 8'h10, 8'h10, 1'b1);
        check("clr_sr_err", {24'h0, bus_m.sr_err}, 32'h00);
        check("clr_cnt", {24'h0, bus_m.err_cnt}, 32'd0);

        for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 8'h01, 8'h01, 1'b0);
        check("sat_cnt_lit", {30'h0, bus_s.err_cnt}, CNT_ON ? 32'd3 : 32'd0);
        check("cnt5_lit", {24'h0, bus_m.err_cnt}, CNT_ON ? 32'd5 : 32'd0);
        check("sat_sr_err_lit", {24'h0, bus_s.sr_err}, 32'h01);

        // Random phase 1: no clears, SR-heavy, drives the wide counter to saturation.
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 5));
            step($urandom_range(0, 9) != 0, (r > 3) ? 2'd2 : r[1:0],
                 8'($urandom), 8'($urandom), 1'b0);
        end
        check("cnt_saturated", {24'h0, bus_m.err_cnt}, CNT_ON ? 32'd255 : 32'd0);

        // Random phase 2: clears and mid-cycle resets mixed in.
        for (int i = 0; i < 2000; i++) begin
            int r = int'($urandom_range(0, 5));
            step($urandom_range(0, 4) != 0, (r > 3) ? 2'd2 : r[1:0],
                 8'($urandom), 8'($urandom), $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
